// File: rtl/menu_pkg.sv
// Shared state codes, datapath page codes and small decode helpers for the
// configuration menu controller.
package menu_pkg;

  // FSM state encoding; db_estado exposes these codes directly.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_SEL_MODO   = 4'd2,
    ST_SEL_BPM    = 4'd3,
    ST_SEL_TOM    = 4'd4,
    ST_SEL_MUSICA = 4'd5,
    ST_SEL_ERRO   = 4'd6,
    ST_DONE       = 4'd7
  } state_t;

  // Page select codes driven to the menu datapath.
  localparam logic [2:0] PAGE_MODO   = 3'b000;
  localparam logic [2:0] PAGE_BPM    = 3'b001;
  localparam logic [2:0] PAGE_TOM    = 3'b010;
  localparam logic [2:0] PAGE_MUSICA = 3'b011;
  localparam logic [2:0] PAGE_ERRO   = 3'b100;

  // True for the five states in which a menu page is being edited.
  function automatic logic is_sel(input state_t s);
    return (s >= ST_SEL_MODO) && (s <= ST_SEL_ERRO);
  endfunction

  // Datapath page shown while in a given selection state.
  function automatic logic [2:0] page_of(input state_t s);
    logic [2:0] p;
    case (s)
      ST_SEL_MODO:   p = PAGE_MODO;
      ST_SEL_BPM:    p = PAGE_BPM;
      ST_SEL_TOM:    p = PAGE_TOM;
      ST_SEL_MUSICA: p = PAGE_MUSICA;
      ST_SEL_ERRO:   p = PAGE_ERRO;
      default:       p = PAGE_MODO;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a level button: one-cycle registered history.
// The history register simply follows the input every cycle, so during reset
// it already holds the current level and a button held across reset gives
// no spurious edge afterwards.
module edge_detector (
  input  logic clock,
  input  logic sinal,
  output logic pulso
);

  logic prev_q;

  // Track the previous button level.
  always_ff @(posedge clock) begin
    prev_q <= sinal;
  end

  assign pulso = sinal & ~prev_q;

endmodule

// File: rtl/menu_controller.sv
// Menu controller: walks the user through mode, tempo, key, song and error
// tolerance pages, captures each confirmed choice, and aborts to IDLE after
// a period of inactivity.
module menu_controller
  import menu_pkg::*;
#(
  parameter int MODO    = 4,
  parameter int BPM     = 2,
  parameter int TOM     = 4,
  parameter int MUSICA  = 16,
  parameter int ERRO    = 3,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic                      confirma,
  input  logic                      voltar,
  input  logic                      atividade,
  input  logic [MODO-1:0]           modos,
  input  logic [BPM-1:0]            bpms,
  input  logic [$clog2(TOM)-1:0]    toms,
  input  logic [$clog2(MUSICA)-1:0] musicas,
  input  logic [ERRO-1:0]           erros,
  output logic [2:0]                menu_sel,
  output logic                      load_initial,
  output logic                      menu_ativo,
  output logic                      config_valida,
  output logic                      timeout_pulse,
  output logic [MODO-1:0]           modo_cfg,
  output logic [BPM-1:0]            bpm_cfg,
  output logic [$clog2(TOM)-1:0]    tom_cfg,
  output logic [$clog2(MUSICA)-1:0] musica_cfg,
  output logic [ERRO-1:0]           erro_cfg,
  output logic [3:0]                db_estado
);

  localparam int TW = $clog2(TOM);
  localparam int SW = $clog2(MUSICA);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic conf_e, volt_e;

  edge_detector u_conf_edge (.clock(clock), .sinal(confirma), .pulso(conf_e));
  edge_detector u_volt_edge (.clock(clock), .sinal(voltar),   .pulso(volt_e));

  state_t          state_q, state_d;
  logic [2:0]      menu_sel_q, menu_sel_d;
  logic            load_q, load_d, ativo_q, ativo_d;
  logic            valida_q, valida_d, tout_q, tout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MODO-1:0] modo_q, modo_d;
  logic [BPM-1:0]  bpm_q, bpm_d;
  logic [TW-1:0]   tom_q, tom_d;
  logic [SW-1:0]   mus_q, mus_d;
  logic [ERRO-1:0] erro_q, erro_d;
  logic            act_s, expire_s;

  // Next-state, capture and inactivity-counter logic.
  always_comb begin
    state_d    = state_q;
    menu_sel_d = menu_sel_q;
    modo_d     = modo_q;
    bpm_d      = bpm_q;
    tom_d      = tom_q;
    mus_d      = mus_q;
    erro_d     = erro_q;
    tout_d     = 1'b0;
    // Any user interaction counts as activity; confirma wins over voltar below.
    act_s      = conf_e | volt_e | atividade;
    expire_s   = is_sel(state_q) && !act_s && (cnt_q == CNT_MAX);

    // Outside the selection pages the counter rests at zero, so entry is clean.
    if (!is_sel(state_q) || act_s || expire_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (expire_s) begin
      state_d = ST_IDLE;
      tout_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iniciar) state_d = ST_LOAD;
          else         state_d = ST_IDLE;
        end
        ST_LOAD: state_d = ST_SEL_MODO;
        ST_SEL_MODO: begin
          if (conf_e) begin
            modo_d  = modos;
            state_d = ST_SEL_BPM;
          end else if (volt_e) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ST_SEL_BPM: begin
          if (conf_e) begin
            bpm_d   = bpms;
            state_d = ST_SEL_TOM;
          end else if (volt_e) begin
            state_d = ST_SEL_MODO;
          end else begin
            state_d = state_q;
          end
        end
        ST_SEL_TOM: begin
          if (conf_e) begin
            tom_d   = toms;
            state_d = ST_SEL_MUSICA;
          end else if (volt_e) begin
            state_d = ST_SEL_BPM;
          end else begin
            state_d = state_q;
          end
        end
        ST_SEL_MUSICA: begin
          if (conf_e) begin
            mus_d = musicas;
            // Free mode has no error-tolerance page.
            if (modo_q[0]) begin
              erro_d  = '0;
              state_d = ST_DONE;
            end else begin
              state_d = ST_SEL_ERRO;
            end
          end else if (volt_e) begin
            state_d = ST_SEL_TOM;
          end else begin
            state_d = state_q;
          end
        end
        ST_SEL_ERRO: begin
          if (conf_e) begin
            erro_d  = erros;
            state_d = ST_DONE;
          end else if (volt_e) begin
            state_d = ST_SEL_MUSICA;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: begin
          if (iniciar)     state_d = ST_LOAD;
          else if (volt_e) state_d = modo_q[0] ? ST_SEL_MUSICA : ST_SEL_ERRO;
          else             state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Page select follows the state into SEL_* and holds elsewhere.
    if (is_sel(state_d)) menu_sel_d = page_of(state_d);
    else                 menu_sel_d = menu_sel_q;

    load_d   = (state_d == ST_LOAD);
    valida_d = (state_d == ST_DONE);
    ativo_d  = is_sel(state_d);
  end

  // State, registered outputs and captured configuration.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      menu_sel_q <= PAGE_MODO;
      load_q     <= 1'b0;
      ativo_q    <= 1'b0;
      valida_q   <= 1'b0;
      tout_q     <= 1'b0;
      cnt_q      <= '0;
      modo_q     <= '0;
      bpm_q      <= '0;
      tom_q      <= '0;
      mus_q      <= '0;
      erro_q     <= '0;
    end else begin
      state_q    <= state_d;
      menu_sel_q <= menu_sel_d;
      load_q     <= load_d;
      ativo_q    <= ativo_d;
      valida_q   <= valida_d;
      tout_q     <= tout_d;
      cnt_q      <= cnt_d;
      modo_q     <= modo_d;
      bpm_q      <= bpm_d;
      tom_q      <= tom_d;
      mus_q      <= mus_d;
      erro_q     <= erro_d;
    end
  end

  assign menu_sel      = menu_sel_q;
  assign load_initial  = load_q;
  assign menu_ativo    = ativo_q;
  assign config_valida = valida_q;
  assign timeout_pulse = tout_q;
  assign modo_cfg      = modo_q;
  assign bpm_cfg       = bpm_q;
  assign tom_cfg       = tom_q;
  assign musica_cfg    = mus_q;
  assign erro_cfg      = erro_q;
  assign db_estado     = state_q;

endmodule
